// File: rtl/read_bus_arbiter_pkg.sv
// ============================================================================
// read_bus_arbiter_pkg : shared widths, FSM encoding and helpers for the
//                        read_bus_arbiter slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package read_bus_arbiter_pkg;

  localparam int M_NUM  = 4;
  localparam int M_ID_W = 2;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [M_ID_W-1:0] onehot_to_idx(input logic [M_NUM-1:0] oh);
    logic [M_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < M_NUM; i++) begin
      if (oh[i]) idx = M_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_bus_arbiter_rr_pick4.sv
// ============================================================================
// rr_pick4 : combinational round-robin picker, first requester at or after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick4
  import read_bus_arbiter_pkg::*;
(
  input  logic [M_NUM-1:0]  req,
  input  logic [M_ID_W-1:0] ptr,
  output logic [M_NUM-1:0]  grant,
  output logic              found
);

  logic [M_ID_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    w_idx = '0;
    for (int k = 0; k < M_NUM; k++) begin
      // Index wraps naturally in M_ID_W bits, giving the modulo-4 search.
      w_idx = ptr + M_ID_W'(k);
      if (!found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/read_bus_arbiter.sv
// ============================================================================
// read_bus_arbiter : round-robin AR-channel arbiter for four read managers
//                    with outstanding-burst cap and R-channel routing by ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

module read_bus_arbiter
  import read_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M_NUM-1:0]        req_rq,
  output logic [M_NUM-1:0]        gnt_rq,
  input  logic [M_NUM-1:0]        m_arvalid,
  output logic [M_NUM-1:0]        m_arready,
  input  logic [M_NUM*ID_W-1:0]   m_arid,
  input  logic [M_NUM*ADDR_W-1:0] m_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [ID_W-1:0]         s_arid,
  output logic [ADDR_W-1:0]       s_araddr,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [ID_W-1:0]         s_rid,
  input  logic                    s_rlast,
  output logic [M_NUM-1:0]        m_rvalid,
  input  logic [M_NUM-1:0]        m_rready,
  output logic [3:0]              outs_cnt
);

  localparam logic [3:0] c_max_outs = 4'(MAX_OUTS);
  localparam logic [3:0] c_cnt_sat  = 4'hF;

  state_t            r_state;
  logic [M_NUM-1:0]  r_gnt;
  logic [M_ID_W-1:0] r_gnt_idx;
  logic [M_ID_W-1:0] r_rr_ptr;
  logic [3:0]        r_outs_cnt;

  logic [M_NUM-1:0]  w_pick_gnt;
  logic              w_pick_found;
  logic              w_granted;
  logic              w_ar_hs;
  logic              w_r_done;
  logic              w_release;
  logic [M_ID_W-1:0] w_rsel;
  logic              w_unused_rid;

  rr_pick4 u_pick (
    .req   (req_rq),
    .ptr   (r_rr_ptr),
    .grant (w_pick_gnt),
    .found (w_pick_found)
  );

  // AR mux: driven straight from the registered grant, no buffering.
  assign w_granted = (r_state == ST_GRANT);
  assign s_arvalid = w_granted & m_arvalid[r_gnt_idx];
  assign s_arid    = w_granted ? m_arid[r_gnt_idx*ID_W +: ID_W] : '0;
  assign s_araddr  = w_granted ? m_araddr[r_gnt_idx*ADDR_W +: ADDR_W] : '0;
  assign m_arready = (w_granted && s_arready) ? r_gnt : '0;

  assign w_ar_hs   = s_arvalid & s_arready;
  assign w_r_done  = s_rvalid & s_rready & s_rlast;
  assign w_release = w_granted & ~req_rq[r_gnt_idx] & ~m_arvalid[r_gnt_idx];

  assign gnt_rq    = r_gnt;
  assign outs_cnt  = r_outs_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found && (r_outs_cnt < c_max_outs)) begin
            r_gnt     <= w_pick_gnt;
            r_gnt_idx <= onehot_to_idx(w_pick_gnt);
            r_state   <= ST_GRANT;
          end else begin
            r_gnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_ar_hs || w_release) begin
            r_gnt    <= '0;
            r_rr_ptr <= r_gnt_idx + 2'd1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating in both directions so a stray rlast can never wrap the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outs_cnt <= '0;
    end else if (w_ar_hs && !w_r_done && (r_outs_cnt != c_cnt_sat)) begin
      r_outs_cnt <= r_outs_cnt + 4'd1;
    end else if (!w_ar_hs && w_r_done && (r_outs_cnt != 4'd0)) begin
      r_outs_cnt <= r_outs_cnt - 4'd1;
    end
  end

  // R return path: upper ID bits carry the owning manager's index.
  assign w_rsel       = s_rid[ID_W-1 -: M_ID_W];
  assign s_rready     = m_rready[w_rsel];
  assign w_unused_rid = ^s_rid[ID_W-M_ID_W-1:0];

  generate
    for (genvar i = 0; i < M_NUM; i++) begin : g_rdemux
      assign m_rvalid[i] = s_rvalid & (w_rsel == M_ID_W'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_read_bus_arbiter.sv
// ============================================================================
// tb_read_bus_arbiter : directed self-checking bench for read_bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_read_bus_arbiter;
  import read_bus_arbiter_pkg::*;

  logic         clk;
  logic         rst;
  logic [3:0]   req_rq;
  logic [3:0]   m_arvalid;
  logic [15:0]  m_arid;
  logic [127:0] m_araddr;
  logic         s_arready;
  logic         s_rvalid;
  logic [3:0]   s_rid;
  logic         s_rlast;
  logic [3:0]   m_rready;

  logic [3:0]   gnt_rq, m_arready, m_rvalid, outs_cnt;
  logic         s_arvalid, s_rready;
  logic [3:0]   s_arid;
  logic [31:0]  s_araddr;

  logic [3:0]   cap_gnt_rq, cap_m_arready, cap_m_rvalid, cap_outs_cnt;
  logic         cap_s_arvalid, cap_s_rready;
  logic [3:0]   cap_s_arid;
  logic [31:0]  cap_s_araddr;

  int n_cmp;
  int n_err;

  read_bus_arbiter #(.MAX_OUTS(4)) dut (
    .clk(clk), .rst(rst), .req_rq(req_rq), .gnt_rq(gnt_rq),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .outs_cnt(outs_cnt)
  );

  read_bus_arbiter #(.MAX_OUTS(2)) dut_cap (
    .clk(clk), .rst(rst), .req_rq(req_rq), .gnt_rq(cap_gnt_rq),
    .m_arvalid(m_arvalid), .m_arready(cap_m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .s_arvalid(cap_s_arvalid), .s_arready(s_arready), .s_arid(cap_s_arid),
    .s_araddr(cap_s_araddr), .s_rvalid(s_rvalid), .s_rready(cap_s_rready), .s_rid(s_rid),
    .s_rlast(s_rlast), .m_rvalid(cap_m_rvalid), .m_rready(m_rready), .outs_cnt(cap_outs_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_id(input int i);
    return 4'(i * 4 + 1);
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic clear_inputs();
    req_rq = '0; m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b0; s_rid = '0; s_rlast = 1'b0; m_rready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_rq = 4'hF; m_arvalid = 4'hF; s_arready = 1'b1;
    s_rvalid = 1'b0; s_rid = 4'b0100; m_rready = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (gnt_rq !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt_rq); end
    n_cmp++; if (outs_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", s_arvalid); end
    n_cmp++; if (m_arready !== 4'b0000) begin n_err++; $display("FAIL reset_arready: got %b want 0000", m_arready); end
    n_cmp++; if (s_araddr !== 32'h0) begin n_err++; $display("FAIL reset_araddr: got %h want 0", s_araddr); end
    n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid: got %b want 0000", m_rvalid); end
    n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL reset_rready: got %b want 1", s_rready); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req_rq = 4'b0100; m_arvalid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (gnt_rq !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt_rq); end
    n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid: got %b want 1", s_arvalid); end
    n_cmp++; if (s_arid !== exp_id(2)) begin n_err++; $display("FAIL single_arid: got %h want %h", s_arid, exp_id(2)); end
    n_cmp++; if (s_araddr !== exp_addr(2)) begin n_err++; $display("FAIL single_araddr: got %h want %h", s_araddr, exp_addr(2)); end
    n_cmp++; if (m_arready !== 4'b0000) begin n_err++; $display("FAIL single_arready_lo: got %b want 0000", m_arready); end
    s_arready = 1'b1;
    #1;
    n_cmp++; if (m_arready !== 4'b0100) begin n_err++; $display("FAIL single_arready_hi: got %b want 0100", m_arready); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (gnt_rq !== 4'b0000) begin n_err++; $display("FAIL single_gnt_clr: got %b want 0000", gnt_rq); end
    n_cmp++; if (outs_cnt !== 4'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", outs_cnt); end
    n_cmp++; if (dut.r_rr_ptr !== 2'd3) begin n_err++; $display("FAIL single_ptr: got %0d want 3", dut.r_rr_ptr); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL single_idle_arvalid: got %b want 0", s_arvalid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req_rq = 4'hF; m_arvalid = 4'hF; s_arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
      exp = 4'b0001 << (k % 4);
      n_cmp++; if (gnt_rq !== exp) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt_rq, exp); end
      n_cmp++; if (s_araddr !== exp_addr(k % 4)) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", k, s_araddr, exp_addr(k % 4)); end
      @(negedge clk);
      n_cmp++; if (gnt_rq !== 4'b0000) begin n_err++; $display("FAIL rr_gap[%0d]: got %b want 0000", k, gnt_rq); end
      if (k == 1) begin
        s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'b0001; m_rready = 4'b0001;
      end
    end
    n_cmp++; if (outs_cnt !== 4'd4) begin n_err++; $display("FAIL rr_cnt: got %0d want 4", outs_cnt); end
    clear_inputs();
  endtask

  task automatic test_outs_cap();
    do_reset();
    req_rq = 4'hF; m_arvalid = 4'hF; s_arready = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (cap_gnt_rq !== 4'b0000) begin n_err++; $display("FAIL cap_block[%0d]: got %b want 0000", k, cap_gnt_rq); end
    end
    n_cmp++; if (cap_outs_cnt !== 4'd2) begin n_err++; $display("FAIL cap_cnt_full: got %0d want 2", cap_outs_cnt); end
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'b1001; m_rready = 4'b0100;
    #1;
    n_cmp++; if (cap_m_rvalid !== 4'b0100) begin n_err++; $display("FAIL cap_rvalid: got %b want 0100", cap_m_rvalid); end
    n_cmp++; if (cap_s_rready !== 1'b1) begin n_err++; $display("FAIL cap_rready: got %b want 1", cap_s_rready); end
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    n_cmp++; if (cap_outs_cnt !== 4'd1) begin n_err++; $display("FAIL cap_cnt_dec: got %0d want 1", cap_outs_cnt); end
    n_cmp++; if (cap_gnt_rq !== 4'b0000) begin n_err++; $display("FAIL cap_gnt_wait: got %b want 0000", cap_gnt_rq); end
    @(negedge clk);
    n_cmp++; if (cap_gnt_rq !== 4'b0100) begin n_err++; $display("FAIL cap_gnt_resume: got %b want 0100", cap_gnt_rq); end
    // AR handshake and rlast handshake land on the same edge.
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'b0000; m_rready = 4'b0001;
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (cap_outs_cnt !== 4'd1) begin n_err++; $display("FAIL simul_cnt: got %0d want 1", cap_outs_cnt); end
    n_cmp++; if (cap_gnt_rq !== 4'b0000) begin n_err++; $display("FAIL simul_gnt: got %b want 0000", cap_gnt_rq); end
  endtask

  task automatic test_r_routing();
    do_reset();
    s_rvalid = 1'b1; s_rid = 4'b1110; m_rready = 4'b1000;
    #1;
    n_cmp++; if (m_rvalid !== 4'b1000) begin n_err++; $display("FAIL route_rvalid: got %b want 1000", m_rvalid); end
    n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL route_rready_hi: got %b want 1", s_rready); end
    m_rready = 4'b0111;
    #1;
    n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL route_rready_lo: got %b want 0", s_rready); end
    m_rready = 4'b1000;
    #1;
    n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL route_rready_back: got %b want 1", s_rready); end
    s_rid = 4'b0111;
    #1;
    n_cmp++; if (m_rvalid !== 4'b0010) begin n_err++; $display("FAIL route_rvalid_m1: got %b want 0010", m_rvalid); end
    s_rvalid = 1'b0;
    #1;
    n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL route_rvalid_off: got %b want 0000", m_rvalid); end
    clear_inputs();
  endtask

  task automatic test_withdraw_reset();
    do_reset();
    req_rq = 4'b0010; m_arvalid = 4'b0000; s_arready = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt_rq !== 4'b0010) begin n_err++; $display("FAIL wd_gnt: got %b want 0010", gnt_rq); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL wd_arvalid: got %b want 0", s_arvalid); end
    n_cmp++; if (m_arready !== 4'b0010) begin n_err++; $display("FAIL wd_arready: got %b want 0010", m_arready); end
    req_rq = 4'b0000;
    @(negedge clk);
    n_cmp++; if (gnt_rq !== 4'b0000) begin n_err++; $display("FAIL wd_release: got %b want 0000", gnt_rq); end
    n_cmp++; if (dut.r_rr_ptr !== 2'd2) begin n_err++; $display("FAIL wd_ptr: got %0d want 2", dut.r_rr_ptr); end
    n_cmp++; if (outs_cnt !== 4'd0) begin n_err++; $display("FAIL wd_cnt: got %0d want 0", outs_cnt); end
    req_rq = 4'hF; m_arvalid = 4'hF;
    repeat (6) @(negedge clk);
    n_cmp++; if (outs_cnt !== 4'd3) begin n_err++; $display("FAIL rst_pre_cnt: got %0d want 3", outs_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++; if (outs_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if (gnt_rq !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", gnt_rq); end
    n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %b want %b", dut.r_state, ST_IDLE); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      m_arid[i*4 +: 4]     = exp_id(i);
      m_araddr[i*32 +: 32] = exp_addr(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_outs_cap();
    test_r_routing();
    test_withdraw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
